mux_sweep_ctrl: RTL and testbench
=================================

// Module: mux_sweep_ctrl
// PURPOSE
//  Sequencer that exhaustively drives the select inputs of a mux-implemented logic
//  function (Mux2/Mux4/Mux8 style, selects = A,B,C). Captures the function output for
//  every select code into a truth-table register and checks it against an expected table.
//  Sits between a start/done host and the combinational function under test.
//  One sweep per start; reports match, mismatch count and lowest failing index.
// PARAMETERS
//  SEL_W   3  select width; table depth N = 2**SEL_W entries
//  SETTLE  2  wait cycles after each select change before sampling (>=1)
// PORTS
//  clk       in   1        system clock, rising edge
//  rst_n     in   1        asynchronous, active-low reset
//  start     in   1        sweep request; accepted only in IDLE
//  expected  in   N        expected table, bit i = Y for sel==i; latched on accept
//  y_in      in   1        output of function under test
//  sel       out  SEL_W    select code to function; sel[0]=A, sel[1]=B, sel[2]=C
//  busy      out  1        high from cycle after accept through DONE cycle
//  done      out  1        one-cycle pulse, sweep complete
//  table     out  N        captured table, bit i = y_in sampled while sel==i
//  match     out  1        table==expected_latched; valid from done, held to next accept
//  err_cnt   out  SEL_W+1  number of mismatching entries
//  err_idx   out  SEL_W    lowest mismatching index; 0 if none
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, sel=0, busy=0, done=0, table=0, match=0,
//    err_cnt=0, err_idx=0, expected latch=0. Registered outputs only; no comb paths.
//  - FSM: IDLE -> WAIT -> SAMPLE -> (WAIT | DONE) -> IDLE.
//  - IDLE: on start=1 at an edge: latch expected; sel<=0; clear table, err_cnt, err_idx,
//    match, error-seen flag; go WAIT with wait counter = SETTLE-1.
//  - WAIT: exactly SETTLE cycles; sel stable; counter decrements; at 0 go SAMPLE.
//  - SAMPLE: one cycle; at its closing edge table[sel]<=y_in; if y_in!=exp[sel] then
//    err_cnt++ and, if no earlier error, err_idx<=sel. If sel==N-1 go DONE, else
//    sel<=sel+1 and go WAIT (counter reload SETTLE-1).
//  - DONE: one cycle; done=1, busy=1; match = (err_cnt==0). Next state IDLE; sel
//    returns to 0 on the DONE->IDLE edge.
//  - Each index occupies SETTLE+1 cycles. Latency: accept edge -> done high in cycle
//    N*(SETTLE+1)+1 (25 cycles for defaults).
//  - start ignored while busy (WAIT/SAMPLE/DONE); no queuing. start held high in IDLE
//    after DONE begins a new sweep immediately (back-to-back, 1 IDLE cycle between).
//  - expected changes after accept have no effect on the current sweep.
//  - sel never exceeds N-1; no wrap-around within a sweep.
//  - table/match/err_* hold their final values in IDLE until the next accept clears them.
//  - Reset mid-sweep: immediate abort, all outputs to reset values, no done pulse.
//  - err_cnt saturation impossible: max N fits SEL_W+1 bits.
// TESTING
//  1 y_in = Mux8 table 0x96 driven by sel, expected=0x96, start 1 cycle -> done in cycle
//    25, table=0x96, match=1, err_cnt=0, err_idx=0; sel visits 0..7, 3 cycles each.
//  2 Same DUT, expected=0x97 -> table=0x96, match=0, err_cnt=1, err_idx=0.
//  3 y_in = table 0x73, expected=0x96 -> err_cnt=5 (diff 0xE5), err_idx=0, match=0.
//  4 Pulse start again at cycle 10 of a sweep, toggle expected -> ignored; single done
//    at cycle 25, results from first latched expected.
//  5 Assert rst_n=0 at cycle 12 mid-sweep -> all outputs 0 asynchronously, no done;
//    new start after release completes normally.
//  6 SETTLE=1 build, start held high continuously -> done every 18 cycles, busy low
//    exactly 1 cycle between sweeps, results valid on each done.

Source files
------------

// File: rtl/mux_sweep_ctrl.sv
// Exhaustive select-sweep sequencer: steps sel through every code, captures the
// function output into a truth table and scores it against a latched expected table.
module mux_sweep_ctrl #(
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [2**SEL_W-1:0]  i_expected,
    input  logic                 i_y_in,
    output logic [SEL_W-1:0]     o_sel,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2**SEL_W-1:0]  o_table,
    output logic                 o_match,
    output logic [SEL_W:0]       o_err_cnt,
    output logic [SEL_W-1:0]     o_err_idx
);
    localparam int unsigned N     = 2**SEL_W;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0] SEL_LAST   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N-1:0]        r_exp;
    logic [CNT_W-1:0]    r_cnt;
    logic [SEL_W-1:0]    r_sel;
    logic                r_busy;
    logic                r_done;
    logic [N-1:0]        r_table;
    logic                r_match;
    logic [SEL_W:0]      r_err_cnt;
    logic [SEL_W-1:0]    r_err_idx;
    logic                w_mismatch;
    logic [SEL_W:0]      w_err_cnt_nxt;

    assign w_mismatch    = (i_y_in != r_exp[r_sel]);
    assign w_err_cnt_nxt = r_err_cnt + {{SEL_W{1'b0}}, w_mismatch};

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (i_start) w_state_nxt = ST_WAIT;
            ST_WAIT:   if (r_cnt == '0) w_state_nxt = ST_SAMPLE;
            ST_SAMPLE: w_state_nxt = (r_sel == SEL_LAST) ? ST_DONE : ST_WAIT;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_exp     <= '0;
            r_cnt     <= '0;
            r_sel     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_table   <= '0;
            r_match   <= 1'b0;
            r_err_cnt <= '0;
            r_err_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_exp     <= i_expected;
                        r_sel     <= '0;
                        r_cnt     <= CNT_RELOAD;
                        r_busy    <= 1'b1;
                        r_table   <= '0;
                        r_match   <= 1'b0;
                        r_err_cnt <= '0;
                        r_err_idx <= '0;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                ST_SAMPLE: begin
                    r_table[r_sel] <= i_y_in;
                    if (w_mismatch) begin
                        r_err_cnt <= w_err_cnt_nxt;
                        // err_cnt still zero means this is the first failing index
                        if (r_err_cnt == '0) r_err_idx <= r_sel;
                    end
                    if (r_sel == SEL_LAST) begin
                        r_done  <= 1'b1;
                        r_match <= (w_err_cnt_nxt == '0);
                    end else begin
                        r_sel <= r_sel + 1'b1;
                        r_cnt <= CNT_RELOAD;
                    end
                end
                ST_DONE: begin
                    r_busy <= 1'b0;
                    r_sel  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_sel     = r_sel;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_table   = r_table;
    assign o_match   = r_match;
    assign o_err_cnt = r_err_cnt;
    assign o_err_idx = r_err_idx;
endmodule

// File: tb/tb_mux_sweep_ctrl.sv
// Directed bench for mux_sweep_ctrl: default build (SETTLE=2) plus a SETTLE=1 build
// driven with start held high for back-to-back sweeps.
module tb_mux_sweep_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;

    logic       start0, start1;
    logic [7:0] exp0, exp1;
    logic [7:0] func0, func1;
    logic       y0, y1;
    logic [2:0] sel0, sel1;
    logic       busy0, busy1, done0, done1, match0, match1;
    logic [7:0] tbl0, tbl1;
    logic [3:0] ecnt0, ecnt1;
    logic [2:0] eidx0, eidx1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign y0 = func0[sel0];
    assign y1 = func1[sel1];

    mux_sweep_ctrl #(.SEL_W(3), .SETTLE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_start(start0), .i_expected(exp0), .i_y_in(y0),
        .o_sel(sel0), .o_busy(busy0), .o_done(done0), .o_table(tbl0),
        .o_match(match0), .o_err_cnt(ecnt0), .o_err_idx(eidx0)
    );

    mux_sweep_ctrl #(.SEL_W(3), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start1), .i_expected(exp1), .i_y_in(y1),
        .o_sel(sel1), .o_busy(busy1), .o_done(done1), .o_table(tbl1),
        .o_match(match1), .o_err_cnt(ecnt1), .o_err_idx(eidx1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full SETTLE=2 sweep on dut0; poke>0 pulses start and flips expected in that cycle.
    task automatic sweep0(input string tag, input logic [7:0] f, input logic [7:0] e,
                          input int poke, input logic [7:0] r_tbl, input logic r_match,
                          input logic [3:0] r_cnt, input logic [2:0] r_idx);
        func0  = f;
        exp0   = e;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            check({tag, "_sel"},  {29'd0, sel0}, (c <= 24) ? (c - 1) / 3 : 7);
            check({tag, "_busy"}, {31'd0, busy0}, 32'd1);
            check({tag, "_done"}, {31'd0, done0}, (c == 25) ? 32'd1 : 32'd0);
            if (c == poke) begin
                start0 = 1'b1;
                exp0   = ~e;
            end
            if (c < 25) begin
                tick();
                start0 = 1'b0;
                exp0   = e;
            end
        end
        check({tag, "_table"}, {24'd0, tbl0}, {24'd0, r_tbl});
        check({tag, "_match"}, {31'd0, match0}, {31'd0, r_match});
        check({tag, "_errcnt"}, {28'd0, ecnt0}, {28'd0, r_cnt});
        check({tag, "_erridx"}, {29'd0, eidx0}, {29'd0, r_idx});
        tick();
        check({tag, "_idle_busy"}, {31'd0, busy0}, 32'd0);
        check({tag, "_idle_done"}, {31'd0, done0}, 32'd0);
        check({tag, "_idle_sel"},  {29'd0, sel0}, 32'd0);
        check({tag, "_hold_table"}, {24'd0, tbl0}, {24'd0, r_tbl});
        check({tag, "_hold_errcnt"}, {28'd0, ecnt0}, {28'd0, r_cnt});
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        exp0   = 8'h00;
        exp1   = 8'h00;
        func0  = 8'h96;
        func1  = 8'h5A;
        tick();
        tick();
        check("rst_sel",    {29'd0, sel0}, 32'd0);
        check("rst_busy",   {31'd0, busy0}, 32'd0);
        check("rst_done",   {31'd0, done0}, 32'd0);
        check("rst_table",  {24'd0, tbl0}, 32'd0);
        check("rst_match",  {31'd0, match0}, 32'd0);
        check("rst_errcnt", {28'd0, ecnt0}, 32'd0);
        check("rst_erridx", {29'd0, eidx0}, 32'd0);
        rst_n = 1'b1;
        tick();

        sweep0("t1_match",  8'h96, 8'h96, 0, 8'h96, 1'b1, 4'd0, 3'd0);
        sweep0("t2_bit0",   8'h96, 8'h97, 0, 8'h96, 1'b0, 4'd1, 3'd0);
        sweep0("t3_multi",  8'h73, 8'h96, 0, 8'h73, 1'b0, 4'd5, 3'd0);
        sweep0("tx_bit4",   8'h96, 8'h86, 0, 8'h96, 1'b0, 4'd1, 3'd4);
        sweep0("t4_ignore", 8'h96, 8'h96, 10, 8'h96, 1'b1, 4'd0, 3'd0);

        // Mid-sweep asynchronous reset: outputs clear between clock edges.
        func0  = 8'h73;
        exp0   = 8'h00;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (11) tick();
        check("t5_pre_busy", {31'd0, busy0}, 32'd1);
        check("t5_pre_sel",  {29'd0, sel0}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_sel",    {29'd0, sel0}, 32'd0);
        check("t5_async_busy",   {31'd0, busy0}, 32'd0);
        check("t5_async_table",  {24'd0, tbl0}, 32'd0);
        check("t5_async_errcnt", {28'd0, ecnt0}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("t5_no_done", {31'd0, done0}, 32'd0);
        end
        rst_n = 1'b1;
        tick();
        sweep0("t5_after", 8'h73, 8'h73, 0, 8'h73, 1'b1, 4'd0, 3'd0);

        // SETTLE=1 build with start held high: 17-cycle sweeps, one IDLE cycle between.
        exp1   = 8'h5A;
        start1 = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            for (int c = 1; c <= 17; c++) begin
                check("t6_sel",  {29'd0, sel1}, (c <= 16) ? (c - 1) / 2 : 7);
                check("t6_busy", {31'd0, busy1}, 32'd1);
                check("t6_done", {31'd0, done1}, (c == 17) ? 32'd1 : 32'd0);
                if (c == 5) exp1 = 8'hFF;
                if (c < 17) tick();
            end
            check("t6_table", {24'd0, tbl1}, 32'h5A);
            case (s)
                0: begin
                    check("t6_s0_match",  {31'd0, match1}, 32'd1);
                    check("t6_s0_errcnt", {28'd0, ecnt1}, 32'd0);
                    exp1 = 8'hDA;
                end
                1: begin
                    check("t6_s1_match",  {31'd0, match1}, 32'd0);
                    check("t6_s1_errcnt", {28'd0, ecnt1}, 32'd1);
                    check("t6_s1_erridx", {29'd0, eidx1}, 32'd7);
                    exp1 = 8'h00;
                end
                default: begin
                    check("t6_s2_match",  {31'd0, match1}, 32'd0);
                    check("t6_s2_errcnt", {28'd0, ecnt1}, 32'd4);
                    check("t6_s2_erridx", {29'd0, eidx1}, 32'd1);
                end
            endcase
            tick();
            check("t6_gap_busy", {31'd0, busy1}, 32'd0);
            check("t6_gap_done", {31'd0, done1}, 32'd0);
            check("t6_gap_sel",  {29'd0, sel1}, 32'd0);
            tick();
        end
        start1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
